bitwise_arbiter: RTL



---
 rtl/bitwise_arb_pkg.sv | 33 +++
 rtl/rr_arb2.sv | 17 +
 rtl/bitwise_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/bitwise_arb_pkg.sv
// Shared types and constants for the bitwise unit arbiter.
//   arb_state_t : arbiter FSM state encoding
//   OPC_*       : op class field, op[3:2]
//   LAT_*       : number of non-WAIT unit states per op class
package bitwise_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  localparam logic [1:0] OPC_MOV = 2'b00;
  localparam logic [1:0] OPC_XOR = 2'b01;
  localparam logic [1:0] OPC_ASL = 2'b10;
  localparam logic [1:0] OPC_SWP = 2'b11;

  localparam int LAT_MOV = 1;
  localparam int LAT_XOR = 3;
  localparam int LAT_ASL = 4;
  localparam int LAT_SWP = 3;

  function automatic int op_latency(input logic [1:0] opc);
    case (opc)
      OPC_MOV: return LAT_MOV;
      OPC_XOR: return LAT_XOR;
      OPC_ASL: return LAT_ASL;
      default: return LAT_SWP;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick.
//   req0, req1 : requests
//   last       : client served most recently
//   valid      : at least one request present
//   pick       : chosen client (0 or 1); on a tie, the one that is not last
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic pick
);

  assign valid = req0 | req1;
  assign pick  = (req0 && req1) ? ~last : req1;

endmodule

// File: rtl/bitwise_arbiter.sv
// Round-robin arbiter sharing one bitwise unit between two clients, with a
// watchdog that aborts a transaction whose done never comes back.
//   clk, reset          : clock, synchronous active-high reset
//   req*/op*/in*        : client request, opcode, immediate
//   gnt*/ack*           : client grant (ISSUE..RESP), one-cycle response strobe
//   result, err         : captured unit output / timeout flag, held between acks
//   bw_s/bw_op/bw_in    : start, opcode, immediate to the unit
//   bw_done/bw_out      : unit idle flag, unit result
//
// state    | meaning
// ST_IDLE  | waiting for a request and an idle unit
// ST_ISSUE | one-cycle start pulse to the unit
// ST_BUSY  | waiting for done, watchdog counting
// ST_RESP  | one-cycle ack to the owner
module bitwise_arbiter
  import bitwise_arb_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] op0,
  input  logic [3:0] op1,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] result,
  output logic       err,
  output logic       bw_s,
  output logic [3:0] bw_op,
  output logic [7:0] bw_in,
  input  logic       bw_done,
  input  logic [7:0] bw_out
);

  localparam int              CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_MAX = '1;
  localparam logic [CW-1:0]   CNT_TC  = CW'(TIMEOUT);

  arb_state_t    state, state_nx;
  logic          owner;
  logic          last;
  logic          rr_valid, rr_pick;
  logic [CW-1:0] wd_cnt, wd_inc;
  logic          wd_expire;
  logic          in_txn, drive_bw;

  rr_arb2 u_rr (
    .req0  (req0),
    .req1  (req1),
    .last  (last),
    .valid (rr_valid),
    .pick  (rr_pick)
  );

  // The abort fires on the BUSY cycle whose incremented count reaches
  // TIMEOUT, so exactly TIMEOUT BUSY cycles elapse before RESP.
  assign wd_inc    = (wd_cnt == CNT_MAX) ? wd_cnt : wd_cnt + 1'b1;
  assign wd_expire = (wd_inc == CNT_TC);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (rr_valid && bw_done) state_nx = ST_ISSUE;
      ST_ISSUE: state_nx = ST_BUSY;
      ST_BUSY:  if (bw_done || wd_expire) state_nx = ST_RESP;
      ST_RESP:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    in_txn   = (state != ST_IDLE);
    drive_bw = (state == ST_ISSUE) || (state == ST_BUSY);
    gnt0     = in_txn && !owner;
    gnt1     = in_txn &&  owner;
    ack0     = (state == ST_RESP) && !owner;
    ack1     = (state == ST_RESP) &&  owner;
    bw_s     = (state == ST_ISSUE);
    bw_op    = 4'd0;
    bw_in    = 8'd0;
    if (drive_bw) begin
      bw_op = owner ? op1 : op0;
      bw_in = owner ? in1 : in0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      owner  <= 1'b0;
      last   <= 1'b1;
      wd_cnt <= '0;
      result <= 8'd0;
      err    <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (rr_valid && bw_done) owner <= rr_pick;
        end
        ST_ISSUE: begin
          wd_cnt <= '0;
        end
        ST_BUSY: begin
          if (bw_done) begin
            result <= bw_out;
            err    <= 1'b0;
          end else begin
            wd_cnt <= wd_inc;
            if (wd_expire) begin
              result <= 8'd0;
              err    <= 1'b1;
            end
          end
        end
        ST_RESP: begin
          last <= owner;
        end
        default: ;
      endcase
    end
  end

endmodule
